// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, fixed-length
//                multi-byte frames with a guaranteed cs-high gap afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
   parameter int CLK_DIV     = 2,
   parameter int FRAME_BYTES = 4
) (
   input  logic                       i_sysClk,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic [8*FRAME_BYTES-1:0]   i_tx_data,
   output logic [8*FRAME_BYTES-1:0]   o_rx_data,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_spiClk,
   output logic                       o_mosi,
   input  logic                       i_miso,
   output logic                       o_cs
);

   localparam int W  = 8 * FRAME_BYTES;
   localparam int BW = $clog2(W);
   localparam int DW = $clog2(CLK_DIV);

   // A half-period of one sysClk cycle would leave no room for the miso register.
   if (CLK_DIV < 2) begin : g_div_check
      $error("spi_master: CLK_DIV must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          r_state;
   logic [DW-1:0]   r_div;
   logic [BW-1:0]   r_bit;
   logic [W-1:0]    r_tx_sh;
   logic [W-1:0]    r_rx_sh;
   logic            r_miso;
   logic            w_div_end;

   assign w_div_end = (r_div == DW'(CLK_DIV - 1));

   // Single register stage on the incoming miso line.
   always_ff @(posedge i_sysClk) begin
      if (i_reset) begin
         r_miso <= 1'b0;
      end else begin
         r_miso <= i_miso;
      end
   end

   // Frame sequencer; every SPI-facing output is driven from a register.
   always_ff @(posedge i_sysClk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit     <= '0;
         r_tx_sh   <= '0;
         r_rx_sh   <= '0;
         o_rx_data <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_spiClk  <= 1'b0;
         o_mosi    <= 1'b0;
         o_cs      <= 1'b1;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  // The first bit goes straight to mosi; the shifter holds the rest.
                  r_tx_sh  <= {i_tx_data[W-2:0], 1'b0};
                  o_mosi   <= i_tx_data[W-1];
                  o_busy   <= 1'b1;
                  o_cs     <= 1'b0;
                  o_spiClk <= 1'b0;
                  r_div    <= '0;
                  r_bit    <= '0;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_div_end) begin
                  r_div    <= '0;
                  o_spiClk <= 1'b1;
                  r_state  <= S_HIGH;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_HIGH: begin
               if (w_div_end) begin
                  r_div    <= '0;
                  o_spiClk <= 1'b0;
                  r_rx_sh  <= {r_rx_sh[W-2:0], r_miso};
                  if (r_bit == BW'(W - 1)) begin
                     // Last bit: mosi stays put through the hold phase.
                     r_state <= S_HOLD;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     o_mosi  <= r_tx_sh[W-1];
                     r_tx_sh <= {r_tx_sh[W-2:0], 1'b0};
                     r_state <= S_LOW;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_LOW: begin
               if (w_div_end) begin
                  r_div    <= '0;
                  o_spiClk <= 1'b1;
                  r_state  <= S_HIGH;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_HOLD: begin
               if (w_div_end) begin
                  r_div     <= '0;
                  o_cs      <= 1'b1;
                  o_done    <= 1'b1;
                  o_mosi    <= 1'b0;
                  o_rx_data <= r_rx_sh;
                  r_state   <= S_GAP;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_GAP: begin
               if (w_div_end) begin
                  r_div   <= '0;
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_master
//  Description : Scoreboard bench for spi_master with a mode-0 slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

   localparam int D       = 2;
   localparam int N       = 4;
   localparam int W       = 8 * N;
   localparam int CS_LOW  = D * (16 * N + 1);
   localparam int LAT     = 1 + CS_LOW;
   localparam int REPEAT  = LAT + D;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_start = 1'b0;
   logic [W-1:0]  i_tx_data = '0;
   logic [W-1:0]  o_rx_data;
   logic          o_busy, o_done, o_spiClk, o_mosi, o_cs;
   logic          i_miso = 1'b0;

   spi_master #(.CLK_DIV(D), .FRAME_BYTES(N)) dut (
      .i_sysClk (clk),
      .i_reset  (i_reset),
      .i_start  (i_start),
      .i_tx_data(i_tx_data),
      .o_rx_data(o_rx_data),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_spiClk (o_spiClk),
      .o_mosi   (o_mosi),
      .i_miso   (i_miso),
      .o_cs     (o_cs)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] rx;
      logic [W-1:0] tx;
      longint       t;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model: loopback or shifting a pattern ----------
   logic         loop_mode = 1'b1;
   logic [W-1:0] slv_pat = '0;
   int           slv_idx = 0;
   logic         slv_prev_sck = 1'b0;

   always @(negedge clk) begin
      if (o_cs !== 1'b0) slv_idx = 0;
      else if (slv_prev_sck && o_spiClk === 1'b0) slv_idx++;
      slv_prev_sck = (o_spiClk === 1'b1);
      if (loop_mode) i_miso = o_mosi;
      else           i_miso = (slv_idx < W) ? slv_pat[W-1-slv_idx] : 1'b0;
   end

   // ---------------- monitor: bus measurement + scoreboard pop ------------
   int           mon_edges = 0;
   int           cs_low_len = 0;
   int           cs_high_run = 0;
   int           done_cnt = 0;
   logic [W-1:0] mcap = '0;
   logic         mon_prev_cs = 1'b1;
   logic         mon_prev_sck = 1'b0;
   exp_t         e;

   always @(negedge clk) begin
      if (o_cs === 1'b0) begin
         if (mon_prev_cs) begin
            chk("cs_high_gap_min", 64'(cs_high_run >= D), 64'd1);
            cs_high_run = 0;
            cs_low_len  = 0;
            mon_edges   = 0;
            mcap        = '0;
         end
         cs_low_len++;
         if (o_spiClk === 1'b1 && !mon_prev_sck) begin
            mon_edges++;
            mcap = {mcap[W-2:0], o_mosi};
         end
      end else begin
         cs_high_run++;
      end
      if (o_done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rx_data",      64'(o_rx_data), 64'(e.rx));
            chk("mosi_stream",  64'(mcap), 64'(e.tx));
            chk("rise_edges",   64'(mon_edges), 64'(W));
            chk("cs_low_len",   64'(cs_low_len), 64'(CS_LOW));
            chk("done_latency", 64'(cyc - e.t), 64'(LAT));
            chk("done_cs_high", 64'(o_cs), 64'd1);
            chk("done_busy",    64'(o_busy), 64'd1);
            chk("done_mosi0",   64'(o_mosi), 64'd0);
         end
      end
      mon_prev_cs  = (o_cs !== 1'b0);
      mon_prev_sck = (o_spiClk === 1'b1);
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) chk("timeout_idle", 64'd1, 64'd0);
   endtask

   task automatic wait_edges(input int k);
      int n = 0;
      do begin
         tick();
         n++;
      end while (mon_edges < k && n < 1000);
      if (n >= 1000) chk("timeout_edges", 64'd1, 64'd0);
   endtask

   task automatic launch(input logic lp, input logic [W-1:0] tx, input logic [W-1:0] pat,
                         input bit expect_done);
      exp_t x;
      loop_mode = lp;
      slv_pat   = pat;
      wait_idle();
      tick();
      i_tx_data = tx;
      i_start   = 1'b1;
      x.rx = lp ? tx : pat;
      x.tx = tx;
      x.t  = cyc;
      if (expect_done) sb.push_back(x);
      tick();
      i_start   = 1'b0;
      i_tx_data = $urandom;
      chk("busy_after_accept", 64'(o_busy), 64'd1);
   endtask

   initial begin
      int d0;
      exp_t x;
      logic [W-1:0] tx2;
      repeat (3) tick();
      i_reset = 1'b0;
      tick();
      chk("rst_cs",   64'(o_cs), 64'd1);
      chk("rst_sck",  64'(o_spiClk), 64'd0);
      chk("rst_mosi", 64'(o_mosi), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_rx",   64'(o_rx_data), 64'd0);

      // directed frames
      launch(1'b1, 32'hA5C30F81, '0, 1'b1);            wait_idle();
      launch(1'b0, 32'h00000000, 32'hDEADBEEF, 1'b1);   wait_idle();
      launch(1'b0, $urandom, 32'hFFFFFFFF, 1'b1);       wait_idle();
      launch(1'b0, $urandom, 32'h00000000, 1'b1);       wait_idle();

      // random frames, random slave behaviour
      for (int i = 0; i < 8; i++) begin
         launch(1'(($urandom % 2)), $urandom, $urandom, 1'b1);
         wait_idle();
      end

      // second start mid-frame is ignored
      d0 = done_cnt;
      launch(1'b0, $urandom, $urandom, 1'b1);
      wait_edges(10);
      i_tx_data = $urandom;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
      wait_idle();
      repeat (4) tick();
      chk("ignored_start_one_done", 64'(done_cnt - d0), 64'd1);
      chk("ignored_start_rx", 64'(o_rx_data), 64'(slv_pat));

      // reset mid-frame aborts without done
      d0 = done_cnt;
      launch(1'b1, $urandom, '0, 1'b0);
      wait_edges(17);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      chk("abort_cs",   64'(o_cs), 64'd1);
      chk("abort_sck",  64'(o_spiClk), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_rx",   64'(o_rx_data), 64'd0);
      repeat (2 * LAT) tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      launch(1'b0, $urandom, $urandom, 1'b1);
      wait_idle();

      // start held high: back-to-back frames accepted right after the gap
      loop_mode = 1'b1;
      wait_idle();
      tick();
      i_tx_data = $urandom;
      i_start   = 1'b1;
      x.rx = i_tx_data; x.tx = i_tx_data; x.t = cyc;
      sb.push_back(x);
      tx2 = $urandom;
      x.rx = tx2; x.tx = tx2; x.t = x.t + REPEAT;
      sb.push_back(x);
      tick();
      i_tx_data = tx2;
      while (cyc < x.t + 3) tick();
      i_start = 1'b0;
      wait_idle();
      repeat (4) tick();

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
